// File: rtl/boolean_algebra.sv
// Four-variable Boolean function unit.
// Samples A..D and sel on every rising edge and presents, one cycle later,
// the selected function value, its complement, the one-hot minterm decode
// and the population count of the inputs. All outputs come from flops so
// nothing on the input side reaches an output combinationally.
module boolean_algebra #(
    parameter logic [15:0] TT = 16'hF0F0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        A,
    input  logic        B,
    input  logic        C,
    input  logic        D,
    input  logic [1:0]  sel,
    output logic        F,
    output logic        F_n,
    output logic [15:0] minterm,
    output logic [2:0]  ones,
    output logic        valid
);

    logic [3:0]  m_idx;
    logic        f_d,       f_q;
    logic [15:0] minterm_d, minterm_q;
    logic [2:0]  ones_d,    ones_q;
    logic        valid_q;

    assign m_idx = {A, B, C, D};

    // Next-state values for every output, computed from the current inputs.
    always_comb begin
        ones_d    = 3'(A) + 3'(B) + 3'(C) + 3'(D);
        minterm_d = 16'h0001 << m_idx;
        f_d       = 1'b0;
        case (sel)
            2'd0:    f_d = (A & B) | (~A & C & D);
            2'd1:    f_d = A ^ B ^ C ^ D;
            2'd2:    f_d = (ones_d >= 3'd3);
            default: f_d = TT[m_idx];
        endcase
    end

    // Output registers; reset clears them immediately, without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q       <= 1'b0;
            minterm_q <= 16'h0000;
            ones_q    <= 3'd0;
            valid_q   <= 1'b0;
        end else begin
            f_q       <= f_d;
            minterm_q <= minterm_d;
            ones_q    <= ones_d;
            valid_q   <= 1'b1;
        end
    end

    assign F       = f_q;
    // Derived from the same flop so F_n is ~F in every cycle, reset included.
    assign F_n     = ~f_q;
    assign minterm = minterm_q;
    assign ones    = ones_q;
    assign valid   = valid_q;

endmodule

// File: tb/tb_boolean_algebra.sv
// Scoreboard bench for boolean_algebra: stimulus pushes hand-computed
// expectations, a monitor pops and compares on every valid output cycle.
module tb_boolean_algebra;

    logic        clk;
    logic        clk_run;
    logic        rst;
    logic        A, B, C, D;
    logic [1:0]  sel;
    logic        F, F_n;
    logic [15:0] minterm;
    logic [2:0]  ones;
    logic        valid;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        f;
        logic [15:0] mt;
        logic [2:0]  on;
    } exp_t;

    exp_t q[$];

    boolean_algebra #(.TT(16'hF0F0)) dut (
        .clk     (clk),
        .rst     (rst),
        .A       (A),
        .B       (B),
        .C       (C),
        .D       (D),
        .sel     (sel),
        .F       (F),
        .F_n     (F_n),
        .minterm (minterm),
        .ones    (ones),
        .valid   (valid)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one vector at the falling edge and record what the next rising edge must produce.
    task automatic apply(input logic [3:0] abcd, input logic [1:0] s,
                         input logic ef, input logic [15:0] emt, input logic [2:0] eon);
        exp_t e;
        @(negedge clk);
        {A, B, C, D} = abcd;
        sel = s;
        e.f  = ef;
        e.mt = emt;
        e.on = eon;
        q.push_back(e);
    endtask

    // Monitor: compare every presented result against the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("scoreboard_underflow", 16'd1, 16'd0);
            end else begin
                e = q.pop_front();
                chk("F",       {15'd0, F},    {15'd0, e.f});
                chk("F_n",     {15'd0, F_n},  {15'd0, ~e.f});
                chk("minterm", minterm,       e.mt);
                chk("ones",    {13'd0, ones}, {13'd0, e.on});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] tt;
        exp_t e;
        tt      = 16'hF0F0;
        clk     = 1'b0;
        clk_run = 1'b0;
        rst     = 1'b1;
        {A, B, C, D} = 4'b0110;
        sel     = 2'd0;

        // Reset with the clock stopped.
        #2;
        chk("rst_F",       {15'd0, F},     16'd0);
        chk("rst_F_n",     {15'd0, F_n},   16'd1);
        chk("rst_minterm", minterm,        16'h0000);
        chk("rst_ones",    {13'd0, ones},  16'd0);
        chk("rst_valid",   {15'd0, valid}, 16'd0);

        // Release and let one edge load 0110 with sel=0: F=0, m=6, ones=2.
        e.f = 1'b0; e.mt = 16'h0040; e.on = 3'd2;
        q.push_back(e);
        rst = 1'b0;
        #1;
        clk_run = 1'b1;
        @(posedge clk);
        #2;
        chk("first_edge_valid", {15'd0, valid}, 16'd1);

        // sel=0 sweep, with an asynchronous reset after the F=1 result of 1100.
        apply(4'b0000, 2'd0, 1'b0, 16'h0001, 3'd0);
        apply(4'b0101, 2'd0, 1'b0, 16'h0020, 3'd2);
        apply(4'b1100, 2'd0, 1'b1, 16'h1000, 3'd2);
        @(posedge clk);
        #2;
        chk("pre_rst_F", {15'd0, F}, 16'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_F",       {15'd0, F},     16'd0);
        chk("async_rst_F_n",     {15'd0, F_n},   16'd1);
        chk("async_rst_valid",   {15'd0, valid}, 16'd0);
        chk("async_rst_minterm", minterm,        16'h0000);
        chk("async_rst_ones",    {13'd0, ones},  16'd0);
        @(negedge clk);
        rst = 1'b0;
        e.f = 1'b1; e.mt = 16'h1000; e.on = 3'd2;
        q.push_back(e);
        apply(4'b1111, 2'd0, 1'b1, 16'h8000, 3'd4);
        apply(4'b0011, 2'd0, 1'b1, 16'h0008, 3'd2);
        apply(4'b1010, 2'd0, 1'b0, 16'h0400, 3'd2);

        // Parity and majority, switching sel on consecutive edges.
        apply(4'b1011, 2'd1, 1'b1, 16'h0800, 3'd3);
        apply(4'b1011, 2'd2, 1'b1, 16'h0800, 3'd3);
        apply(4'b1001, 2'd1, 1'b0, 16'h0200, 3'd2);
        apply(4'b1001, 2'd2, 1'b0, 16'h0200, 3'd2);
        apply(4'b1111, 2'd1, 1'b0, 16'h8000, 3'd4);
        apply(4'b1111, 2'd2, 1'b1, 16'h8000, 3'd4);
        apply(4'b0111, 2'd2, 1'b1, 16'h0080, 3'd3);
        apply(4'b0001, 2'd1, 1'b1, 16'h0002, 3'd1);
        apply(4'b0001, 2'd2, 1'b0, 16'h0002, 3'd1);
        apply(4'b0111, 2'd0, 1'b1, 16'h0080, 3'd3);

        // Truth-table mode, all sixteen minterms.
        for (int m = 0; m < 16; m++) begin
            logic [3:0] mi;
            mi = 4'(m);
            apply(mi, 2'd3, tt[mi], 16'h0001 << mi, 3'($countones(mi)));
        end

        @(posedge clk);
        #3;
        clk_run = 1'b0;
        chk("scoreboard_drained", 16'(q.size()), 16'd0);
        chk("valid_held", {15'd0, valid}, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/boolean_algebra.md
BOOLEAN_ALGEBRA -- requirements
Module: boolean_algebra

Interface
REQ-001 The block SHALL have parameter TT, default 16'hF0F0, meaning the truth table used when sel=3; bit index = minterm number.
REQ-002 The block SHALL have port clk, input, 1, meaning the rising-edge clock for all registers.
REQ-003 The block SHALL have port rst, input, 1, meaning reset; asynchronous, active-high.
REQ-004 The block SHALL have ports A, B, C, D, each input, 1, meaning the Boolean variables; minterm index m = {A,B,C,D}, with A as the MSB.
REQ-005 The block SHALL have port sel, input, 2, meaning the function select.
REQ-006 The block SHALL have port F, output, 1, meaning the registered selected function value.
REQ-007 The block SHALL have port F_n, output, 1, meaning the registered complement of F.
REQ-008 The block SHALL have port minterm, output, 16, meaning registered one-hot decode: bit m = 1, all others 0.
REQ-009 The block SHALL have port ones, output, 3, meaning the registered count of 1s among A, B, C, D (0..4).
REQ-010 The block SHALL have port valid, output, 1, meaning the registered outputs hold a sampled result.

Function
REQ-011 For sel=0, F SHALL be A·B + A'·C·D.
REQ-012 For sel=1, F SHALL be A xor B xor C xor D (odd parity).
REQ-013 For sel=2, F SHALL be 1 when at least 3 of the 4 inputs are 1 (majority).
REQ-014 For sel=3, F SHALL be TT[m].
REQ-015 All outputs SHALL be registered, with exactly 1-cycle latency: inputs sampled at rising edge N appear on the outputs after edge N.
REQ-016 There SHALL be no combinational path from any input to any output.
REQ-017 F_n SHALL equal ~F in every cycle, including during reset.
REQ-018 minterm SHALL always be exactly one-hot once valid=1.
REQ-019 ones SHALL equal A+B+C+D using zero-extended 3-bit addition, with no overflow (maximum value 4).
REQ-020 A change of sel SHALL take effect on the next edge together with A–D; no extra latency.
REQ-021 X or Z on any input is outside the specified range; outputs under X/Z input are unspecified.

Reset
REQ-022 While rst=1, the following SHALL hold immediately, without waiting for a clock edge: F=0, F_n=1, minterm=16'h0000, ones=0, valid=0.
REQ-023 After rst is deasserted, the first rising edge SHALL load the outputs from the current inputs and set valid=1.
REQ-024 valid SHALL remain 1 until the next reset.
REQ-025 Asserting rst mid-operation SHALL clear all outputs asynchronously, independent of clk.

Verification
REQ-026 Reset check: assert rst with clk stopped -> F=0, F_n=1, minterm=0, ones=0, valid=0; release rst and apply one edge -> valid=1.
REQ-027 sel=0 sweep: apply ABCD = 0000, 0101, 1100, 1111, 0011, 1010, one per edge.
  - F one cycle later SHALL be 0, 0, 1, 1, 1, 0.
  - ones SHALL be 0, 2, 2, 4, 2, 2.
  - minterm SHALL be 16'h0001, 16'h0020, 16'h1000, 16'h8000, 16'h0008, 16'h0400.
REQ-028 sel=1 and sel=2 with ABCD = 1011 -> F=1 for parity and F=1 for majority; with ABCD = 1001 -> F=0 for both.
REQ-029 sel=3 with TT default, exhaustive sweep of m = 0..15 -> F = TT[m]; F_n = ~F in every cycle.
REQ-030 Asynchronous reset mid-sweep: assert rst between edges while F=1 -> F=0 and valid=0 before the next edge; after release, the first edge yields the correct result for the current inputs.
